// File: rtl/select_arbiter_pkg.sv
// Shared types for the two-source round-robin select arbiter.
// State codes, priority pointer values and hold-counter sizing.
package select_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10
  } state_e;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  function automatic int hold_w(input int max_hold);
    return (max_hold <= 2) ? 1 : $clog2(max_hold);
  endfunction

endpackage

// File: rtl/select_arbiter_if.sv
// Request/grant/data bundle between two producers,
// the arbiter and the shared sink.
interface select_arbiter_if #(
  parameter int W = 8
);
  logic         req_a;
  logic         req_b;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic         last_a;
  logic         last_b;
  logic         gnt_a;
  logic         gnt_b;
  logic         sel;
  logic         out_valid;
  logic [W-1:0] out_data;

  modport master (
    output req_a, req_b, data_a, data_b,
    output last_a, last_b,
    input  gnt_a, gnt_b, sel,
    input  out_valid, out_data
  );

  modport slave (
    input  req_a, req_b, data_a, data_b,
    input  last_a, last_b,
    output gnt_a, gnt_b, sel,
    output out_valid, out_data
  );
endinterface

// File: rtl/select_arbiter_w.sv
// W-bit 2:1 data mux; sel_i=1 routes a_i.
module select_w #(
  parameter int W = 8
) (
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = sel_i ? a_i : b_i;
endmodule

// File: rtl/select_arbiter.sv
// Round-robin owner of a 2:1 mux select with burst hold,
// last-beat release and a per-tenure beat limit.
module select_arbiter
  import select_arbiter_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst,
  select_arbiter_if.slave  bus
);
  localparam int HW = hold_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_e        state_q, state_d;
  prio_e         prio_q, prio_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          gnt_a_q, gnt_b_q, sel_q;
  logic          rel_a, rel_b;
  logic          grant_a, grant_b;

  // abandon, last beat, or the beat that reaches the limit
  assign rel_a = !bus.req_a || bus.last_a || (hold_q == HOLD_LAST);
  assign rel_b = !bus.req_b || bus.last_b || (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    hold_d  = hold_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_a && (!bus.req_b || prio_q == PRIO_A))
          grant_a = 1'b1;
        else if (bus.req_b)
          grant_b = 1'b1;
      end
      ST_OWN_A: begin
        if (!rel_a)
          hold_d = hold_q + HW'(1);
        else if (bus.req_b)
          grant_b = 1'b1;
        else if (bus.req_a)
          grant_a = 1'b1;
        else
          state_d = ST_IDLE;
      end
      ST_OWN_B: begin
        if (!rel_b)
          hold_d = hold_q + HW'(1);
        else if (bus.req_a)
          grant_a = 1'b1;
        else if (bus.req_b)
          grant_b = 1'b1;
        else
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant_a) begin
      state_d = ST_OWN_A;
      prio_d  = PRIO_B;
    end
    if (grant_b) begin
      state_d = ST_OWN_B;
      prio_d  = PRIO_A;
    end
    if (grant_a || grant_b || state_d == ST_IDLE)
      hold_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= PRIO_A;
      hold_q  <= '0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      hold_q  <= hold_d;
      gnt_a_q <= (state_d == ST_OWN_A);
      gnt_b_q <= (state_d == ST_OWN_B);
      sel_q   <= (state_d == ST_OWN_A);
    end
  end

  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = (gnt_a_q & bus.req_a)
                       | (gnt_b_q & bus.req_b);

  select_w #(.W(W)) u_mux (
    .sel_i (sel_q),
    .a_i   (bus.data_a),
    .b_i   (bus.data_b),
    .y_o   (bus.out_data)
  );
endmodule

// File: tb/tb_select_arbiter.sv
// Directed bench for select_arbiter (W=8, MAX_HOLD=4).
module tb_select_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  select_arbiter_if #(.W(8)) bus ();

  select_arbiter #(.W(8), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.last_a = 1'b0;
    bus.last_b = 1'b0;
    bus.data_a = 8'h00;
    bus.data_b = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_tests++;
    if (bus.gnt_a !== 1'b0) begin
      $display("FAIL reset_gnt_a: got %b want 0", bus.gnt_a); n_fail++;
    end
    n_tests++;
    if (bus.gnt_b !== 1'b0) begin
      $display("FAIL reset_gnt_b: got %b want 0", bus.gnt_b); n_fail++;
    end
    n_tests++;
    if (bus.sel !== 1'b0) begin
      $display("FAIL reset_sel: got %b want 0", bus.sel); n_fail++;
    end
    do_reset();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL reset_valid: got %b want 0", bus.out_valid); n_fail++;
    end
  endtask

  task automatic test_single_a();
    do_reset();
    bus.req_a = 1'b1;
    bus.data_a = 8'h3C;
    bus.data_b = 8'hC3;
    #1;
    n_tests++;
    if (bus.gnt_a !== 1'b0) begin
      $display("FAIL single_pre_gnt: got %b want 0", bus.gnt_a); n_fail++;
    end
    tick();
    n_tests++;
    if ({bus.gnt_a, bus.gnt_b, bus.sel} !== 3'b101) begin
      $display("FAIL single_gnt: got %b want 101",
               {bus.gnt_a, bus.gnt_b, bus.sel}); n_fail++;
    end
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      $display("FAIL single_data: got %b/%h want 1/3c",
               bus.out_valid, bus.out_data); n_fail++;
    end
    bus.req_a = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL single_drop_valid: got %b want 0", bus.out_valid); n_fail++;
    end
    tick();
    n_tests++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b00) begin
      $display("FAIL single_idle: got %b want 00",
               {bus.gnt_a, bus.gnt_b}); n_fail++;
    end
  endtask

  task automatic test_last_switch();
    do_reset();
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    bus.data_a = 8'hAA;
    bus.data_b = 8'h55;
    tick();
    n_tests++;
    if (bus.gnt_a !== 1'b1 || bus.out_data !== 8'hAA) begin
      $display("FAIL last_first_a: got %b/%h want 1/aa",
               bus.gnt_a, bus.out_data); n_fail++;
    end
    tick();
    bus.last_a = 1'b1;
    n_tests++;
    if (bus.gnt_a !== 1'b1 || bus.out_valid !== 1'b1) begin
      $display("FAIL last_beat2: got %b/%b want 1/1",
               bus.gnt_a, bus.out_valid); n_fail++;
    end
    tick();
    bus.last_a = 1'b0;
    n_tests++;
    if ({bus.gnt_a, bus.gnt_b, bus.sel} !== 3'b010) begin
      $display("FAIL last_switch: got %b want 010",
               {bus.gnt_a, bus.gnt_b, bus.sel}); n_fail++;
    end
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55) begin
      $display("FAIL last_b_data: got %b/%h want 1/55",
               bus.out_valid, bus.out_data); n_fail++;
    end
  endtask

  task automatic test_alternate();
    logic exp_a;
    do_reset();
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    bus.data_a = 8'h11;
    bus.data_b = 8'h22;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_a = ((k / 4) % 2) == 0;
      n_tests++;
      if ({bus.gnt_a, bus.gnt_b, bus.out_valid} !== {exp_a, !exp_a, 1'b1}) begin
        $display("FAIL alt_cycle%0d: got %b want %b", k,
                 {bus.gnt_a, bus.gnt_b, bus.out_valid},
                 {exp_a, !exp_a, 1'b1}); n_fail++;
      end
      n_tests++;
      if (bus.out_data !== (exp_a ? 8'h11 : 8'h22)) begin
        $display("FAIL alt_data%0d: got %h want %h", k, bus.out_data,
                 exp_a ? 8'h11 : 8'h22); n_fail++;
      end
    end
  endtask

  task automatic test_a_only();
    do_reset();
    bus.req_a = 1'b1;
    bus.last_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_tests++;
      if ({bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid} !== 4'b1011) begin
        $display("FAIL a_only_cycle%0d: got %b want 1011", k,
                 {bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid}); n_fail++;
      end
    end
    bus.last_b = 1'b0;
  endtask

  task automatic test_abandon();
    do_reset();
    bus.req_a = 1'b1;
    tick();
    bus.req_a = 1'b0;
    bus.req_b = 1'b1;
    #1;
    n_tests++;
    if (bus.gnt_a !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL abandon_hold: got %b/%b want 1/0",
               bus.gnt_a, bus.out_valid); n_fail++;
    end
    tick();
    n_tests++;
    if ({bus.gnt_a, bus.gnt_b, bus.sel} !== 3'b010) begin
      $display("FAIL abandon_to_b: got %b want 010",
               {bus.gnt_a, bus.gnt_b, bus.sel}); n_fail++;
    end
    bus.req_b = 1'b0;
    tick();
    n_tests++;
    if ({bus.gnt_a, bus.gnt_b, bus.out_valid} !== 3'b000) begin
      $display("FAIL abandon_idle: got %b want 000",
               {bus.gnt_a, bus.gnt_b, bus.out_valid}); n_fail++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.gnt_a, bus.gnt_b, bus.sel} !== 3'b000) begin
      $display("FAIL async_clear: got %b want 000",
               {bus.gnt_a, bus.gnt_b, bus.sel}); n_fail++;
    end
    #1;
    rst = 1'b0;
    tick();
    n_tests++;
    if ({bus.gnt_a, bus.gnt_b, bus.sel} !== 3'b101) begin
      $display("FAIL async_regrant_a: got %b want 101",
               {bus.gnt_a, bus.gnt_b, bus.sel}); n_fail++;
    end
  endtask

  initial begin
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.last_a = 1'b0;
    bus.last_b = 1'b0;
    bus.data_a = 8'h00;
    bus.data_b = 8'h00;
    test_reset();
    test_single_a();
    test_last_switch();
    test_alternate();
    test_a_only();
    test_abandon();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/select_arbiter.md
Name: select_arbiter

Overview:
- Two-requester round-robin arbiter that owns the select line of a W-bit 2:1 data mux, sharing one downstream sink between sources A and B.
- Grants are registered and held for a burst: until the owner signals last, drops its request, or hits the MAX_HOLD fairness limit.
- Sits between two producer blocks and a single consumer.
- Provides sel, per-side grants and the muxed data/valid.

Parameters:
W, 8, data width of each source and of out_data
MAX_HOLD, 4, maximum beats one owner may keep the grant per tenure (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_a  in  1  source A requests / has a valid beat
req_b  in  1  source B requests / has a valid beat
data_a  in  W  source A data
data_b  in  W  source B data
last_a  in  1  A's current beat ends its burst (qualified by gnt_a & req_a)
last_b  in  1  B's current beat ends its burst (qualified by gnt_b & req_b)
gnt_a  out  1  A owns the sink (registered)
gnt_b  out  1  B owns the sink (registered)
sel  out  1  mux select: 1 routes data_a, 0 routes data_b (registered)
out_valid  out  1  beat transferred this cycle
out_data  out  W  sel ? data_a : data_b (combinational from registered sel)

Behaviour:
- Reset: state IDLE, gnt_a=0, gnt_b=0, sel=0, hold_cnt=0, prio pointer=A. Asserting rst mid-burst clears all of these immediately, not on a clock edge. The first grant after reset release goes to A if both request.
- States:
  - IDLE: no grant.
  - OWN_A: gnt_a=1, sel=1.
  - OWN_B: gnt_b=1, sel=0.
  - Encoding is one-hot or 2-bit; 2'b11 is illegal and recovers to IDLE.
- Beat: a cycle with the owner's gnt=1 and req=1. out_valid = (gnt_a&req_a)|(gnt_b&req_b). Data passes combinationally in the same cycle.
- hold_cnt increments on each beat and resets to 0 on every ownership change or re-grant.
- Owner release condition, evaluated each cycle in OWN_x:
  - req_x=0 (abandon), or
  - beat with last_x=1, or
  - beat with hold_cnt==MAX_HOLD-1.
- On release, next state is chosen from current requests:
  - Other side requesting: switch directly to OWN_other, with no IDLE bubble.
  - Else if the releasing side is still requesting and released by last/limit: re-grant the same side with hold_cnt=0. Grant stays high; one tenure ends and another starts.
  - Else: go to IDLE.
- IDLE: a single request is granted on the next edge. With both requesting, grant the side the prio pointer names.
- The pointer updates on every grant to point to the side not granted.
- Grant latency from IDLE: request seen at edge N, gnt high after edge N, first beat possible in cycle N+1.
- gnt_a and gnt_b are never simultaneously 1. sel changes only on an edge where ownership changes.
- last_x without req_x, or without gnt_x, is ignored.
- MAX_HOLD=1 forces alternation every beat when both request.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE, ST_OWN_A, ST_OWN_B;
  - the PRIO_A/PRIO_B pointer constants;
  - the hold-counter width, clog2(MAX_HOLD) with a minimum of 1.
- One natural sub-module: select_w, a W-bit 2:1 mux (sel=1 chooses input a), instantiated for out_data.
- FSM, pointer and counter stay in select_arbiter.

Test Plan:
- Reset then req_a=1, data_a=8'h3C, req_b=0 -> gnt_a=1, sel=1 one edge later; out_valid=1, out_data=8'h3C; gnt_b=0 throughout.
- Both request from IDLE after reset -> A granted first. A asserts last_a on its 2nd beat -> next edge gnt_b=1, sel=0, no idle cycle, out_data=data_b.
- Both request continuously, no last, MAX_HOLD=4 -> grants alternate exactly 4 beats A, 4 beats B, ..., with out_valid=1 every cycle.
- Only A requests continuously, never last -> gnt_a stays 1, hold_cnt wraps 0..3 repeatedly, sel constant 1.
- Owner abandons: gnt_a=1, req_a drops while req_b=1 -> gnt_b=1 next edge. If req_b=0 too -> IDLE, out_valid=0.
- rst asserted asynchronously mid-burst (between edges) -> gnt_a/gnt_b/sel go to 0 immediately. After release, with both requesting, A is granted first.
